// File: rtl/sobel_host_pkg.sv
// Shared definitions for the Sobel host-side controller.
//   - default frame geometry and key width
//   - one-hot controller state encoding (same style as the kernel FSM)
package sobel_host_pkg;

    localparam int IMG_W_DEF  = 512;
    localparam int IMG_H_DEF  = 512;
    localparam int ADDR_W_DEF = 18;
    localparam int KEY_W_DEF  = 6;

    typedef enum logic [5:0] {
        S_IDLE  = 6'b000001,
        S_LOAD  = 6'b000010,
        S_START = 6'b000100,
        S_RUN   = 6'b001000,
        S_DRAIN = 6'b010000,
        S_FIN   = 6'b100000
    } state_e;

endpackage

// File: rtl/sobel_rd_skid.sv
// Adapter from a 1-cycle-latency RAM read port to a valid/ready stream.
// Holds an output register plus a one-entry skid register so a read can be
// issued every cycle while the consumer keeps ready high.
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   rd_issue_i         a read is issued this cycle (RAM ce)
//   rd_tag_i           sideband travelling with the issued read
//   rd_q_i             RAM read data, valid the cycle after rd_issue_i
//   can_issue_o        a read issued now is guaranteed a place to land
//   m_valid_o/m_ready_i/m_data_o/m_tag_o  output stream
module sobel_rd_skid #(
    parameter int DATA_W = 8,
    parameter int TAG_W  = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rd_issue_i,
    input  logic [TAG_W-1:0]  rd_tag_i,
    input  logic [DATA_W-1:0] rd_q_i,
    output logic              can_issue_o,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic [DATA_W-1:0] m_data_o,
    output logic [TAG_W-1:0]  m_tag_o
);

    logic              inflt_q;
    logic [TAG_W-1:0]  inflt_tag_q;
    logic              out_vld_q;
    logic [DATA_W-1:0] out_data_q;
    logic [TAG_W-1:0]  out_tag_q;
    logic              skid_vld_q;
    logic [DATA_W-1:0] skid_data_q;
    logic [TAG_W-1:0]  skid_tag_q;

    logic pop;
    logic out_free;
    logic to_skid;

    assign pop      = out_vld_q & m_ready_i;
    assign out_free = ~out_vld_q | pop;
    // Returning data parks in the skid register when the output register is
    // held, or when the output register is being refilled from the skid.
    assign to_skid  = inflt_q & (~out_free | skid_vld_q);

    // With the skid empty, a new read can always land: either the output
    // register frees up, or nothing else is in flight to compete for the skid.
    assign can_issue_o = ~skid_vld_q & (out_free | ~inflt_q);

    assign m_valid_o = out_vld_q;
    assign m_data_o  = out_data_q;
    assign m_tag_o   = out_tag_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inflt_q    <= 1'b0;
            out_vld_q  <= 1'b0;
            skid_vld_q <= 1'b0;
        end else begin
            inflt_q <= rd_issue_i;
            if (out_free) begin
                out_vld_q  <= skid_vld_q | inflt_q;
                skid_vld_q <= skid_vld_q & inflt_q;
            end else if (inflt_q) begin
                skid_vld_q <= 1'b1;
            end
        end
    end

    // ---- stage: read issue -> RAM data return ----
    always_ff @(posedge clk_i) begin
        if (rd_issue_i) begin
            inflt_tag_q <= rd_tag_i;
        end
        if (to_skid) begin
            skid_data_q <= rd_q_i;
            skid_tag_q  <= inflt_tag_q;
        end
    end

    // ---- stage: skid / return data -> output register ----
    // The output data register is cleared on reset so m_data reads zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_data_q <= '0;
            out_tag_q  <= '0;
        end else if (out_free) begin
            if (skid_vld_q) begin
                out_data_q <= skid_data_q;
                out_tag_q  <= skid_tag_q;
            end else if (inflt_q) begin
                out_data_q <= rd_q_i;
                out_tag_q  <= inflt_tag_q;
            end
        end
    end

endmodule

// File: rtl/sobel_host_ctrl.sv
// Host-side driver for the Sobel kernel (ap_ctrl_hs) and its frame RAMs.
// Loads a frame from the input stream into the kernel input RAM, starts the
// kernel with the latched key, waits for done, then streams the whole output
// RAM back out in address order.
// Ports:
//   ap_clk, ap_rst                     clock, synchronous active-high reset
//   cmd_start, cmd_key, busy, job_done job control
//   s_valid/s_ready/s_data             input pixel stream
//   m_valid/m_ready/m_data/m_last      output pixel stream
//   in_mem_*                           kernel input RAM write port
//   out_mem_*                          kernel output RAM read port
//   k_ap_*, k_working_key              kernel control handshake
module sobel_host_ctrl
    import sobel_host_pkg::*;
#(
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int KEY_W  = KEY_W_DEF
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              cmd_start,
    input  logic [KEY_W-1:0]  cmd_key,
    output logic              busy,
    output logic              job_done,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [7:0]        s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [7:0]        m_data,
    output logic              m_last,
    output logic [ADDR_W-1:0] in_mem_address0,
    output logic              in_mem_ce0,
    output logic              in_mem_we0,
    output logic [7:0]        in_mem_d0,
    output logic [ADDR_W-1:0] out_mem_address0,
    output logic              out_mem_ce0,
    input  logic [7:0]        out_mem_q0,
    output logic              k_ap_start,
    input  logic              k_ap_done,
    input  logic              k_ap_idle,
    input  logic              k_ap_ready,
    output logic [KEY_W-1:0]  k_working_key
);

    // One extra counter bit lets the terminal count be reached without wrap.
    localparam logic [ADDR_W:0] NPIX = (ADDR_W+1)'(IMG_W * IMG_H);
    localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] LAST = NPIX - ONE;

    state_e             state_q, state_d;
    logic [ADDR_W:0]    cnt_q, cnt_d;
    logic [KEY_W-1:0]   key_q, key_d;

    logic               rd_issue;
    logic               can_issue;
    logic [0:0]         rd_last;
    logic [0:0]         sk_last;

    // ap_idle carries no information the controller needs.
    logic unused_idle;
    assign unused_idle = k_ap_idle;

    assign rd_last = (cnt_q == LAST);
    assign m_last  = m_valid & sk_last[0];

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            key_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        key_d            = key_q;
        busy             = 1'b1;
        job_done         = 1'b0;
        s_ready          = 1'b0;
        in_mem_address0  = '0;
        in_mem_ce0       = 1'b0;
        in_mem_we0       = 1'b0;
        in_mem_d0        = '0;
        out_mem_address0 = '0;
        out_mem_ce0      = 1'b0;
        rd_issue         = 1'b0;
        k_ap_start       = 1'b0;
        k_working_key    = key_q;

        unique case (state_q)
            S_IDLE: begin
                busy          = 1'b0;
                k_working_key = '0;
                if (cmd_start) begin
                    key_d   = cmd_key;
                    cnt_d   = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    in_mem_ce0      = 1'b1;
                    in_mem_we0      = 1'b1;
                    in_mem_address0 = cnt_q[ADDR_W-1:0];
                    in_mem_d0       = s_data;
                    cnt_d           = cnt_q + ONE;
                    if (cnt_q == LAST) begin
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
                k_ap_start = 1'b1;
                if (k_ap_ready) begin
                    cnt_d   = '0;
                    // A kernel that finishes in the accepting cycle skips RUN.
                    state_d = k_ap_done ? S_DRAIN : S_RUN;
                end
            end
            S_RUN: begin
                if (k_ap_done) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // cnt_q counts reads issued; the skid adapter paces them.
                if ((cnt_q != NPIX) && can_issue) begin
                    rd_issue         = 1'b1;
                    out_mem_ce0      = 1'b1;
                    out_mem_address0 = cnt_q[ADDR_W-1:0];
                    cnt_d            = cnt_q + ONE;
                end
                if (m_valid && m_ready && sk_last[0]) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                job_done = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    sobel_rd_skid #(
        .DATA_W (8),
        .TAG_W  (1)
    ) u_rd_skid (
        .clk_i       (ap_clk),
        .rst_i       (ap_rst),
        .rd_issue_i  (rd_issue),
        .rd_tag_i    (rd_last),
        .rd_q_i      (out_mem_q0),
        .can_issue_o (can_issue),
        .m_valid_o   (m_valid),
        .m_ready_i   (m_ready),
        .m_data_o    (m_data),
        .m_tag_o     (sk_last)
    );

endmodule

// File: tb/tb_sobel_host_ctrl.sv
module tb_sobel_host_ctrl;

    localparam int IW = 4;
    localparam int IH = 4;
    localparam int AW = 4;
    localparam int KW = 6;
    localparam int NP = IW * IH;

    logic          ap_clk = 1'b0;
    logic          ap_rst = 1'b1;
    logic          cmd_start = 1'b0;
    logic [KW-1:0] cmd_key = '0;
    logic          busy, job_done;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [7:0]    s_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic [7:0]    m_data;
    logic          m_last;
    logic [AW-1:0] in_mem_address0;
    logic          in_mem_ce0, in_mem_we0;
    logic [7:0]    in_mem_d0;
    logic [AW-1:0] out_mem_address0;
    logic          out_mem_ce0;
    logic [7:0]    out_mem_q0 = '0;
    logic          k_ap_start, k_ap_done, k_ap_idle, k_ap_ready;
    logic [KW-1:0] k_working_key;

    always #5 ap_clk = ~ap_clk;

    sobel_host_ctrl #(
        .IMG_W(IW), .IMG_H(IH), .ADDR_W(AW), .KEY_W(KW)
    ) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .cmd_start(cmd_start), .cmd_key(cmd_key),
        .busy(busy), .job_done(job_done),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .in_mem_address0(in_mem_address0), .in_mem_ce0(in_mem_ce0),
        .in_mem_we0(in_mem_we0), .in_mem_d0(in_mem_d0),
        .out_mem_address0(out_mem_address0), .out_mem_ce0(out_mem_ce0),
        .out_mem_q0(out_mem_q0),
        .k_ap_start(k_ap_start), .k_ap_done(k_ap_done),
        .k_ap_idle(k_ap_idle), .k_ap_ready(k_ap_ready),
        .k_working_key(k_working_key)
    );

    // Every output that has a defined reset value, packed for one comparison.
    logic [38:0] ovec;
    assign ovec = {busy, job_done, s_ready, m_valid, m_last, m_data,
                   in_mem_address0, in_mem_ce0, in_mem_we0, in_mem_d0,
                   out_mem_address0, out_mem_ce0, k_ap_start, k_working_key};

    // Output RAM model: 1-cycle read latency.
    logic [7:0] omem [NP];
    always @(posedge ap_clk) begin
        if (out_mem_ce0) out_mem_q0 <= omem[out_mem_address0];
    end

    // Kernel model: ready after rdy_delay cycles of start, done done_delay
    // cycles after the start handshake.
    int   rdy_delay = 1;
    int   done_delay = 20;
    int   kc = 0;
    int   dc = 0;
    logic krun = 1'b0;
    assign k_ap_ready = k_ap_start && (kc >= rdy_delay);
    assign k_ap_done  = krun && (dc >= done_delay);
    assign k_ap_idle  = !krun;
    always @(posedge ap_clk) begin
        if (ap_rst) begin
            kc <= 0; dc <= 0; krun <= 1'b0;
        end else begin
            if (k_ap_start && !k_ap_ready) kc <= kc + 1;
            else kc <= 0;
            if (k_ap_start && k_ap_ready) begin
                krun <= 1'b1; dc <= 1;
            end else if (krun) begin
                if (dc >= done_delay) krun <= 1'b0;
                else dc <= dc + 1;
            end
        end
    end

    // Output ready pattern: mode 0 always ready, mode 1 repeats 1,0,0,1.
    int mr_mode = 0;
    int mcyc = 0;
    initial forever begin
        @(posedge ap_clk); #1;
        mcyc++;
        if (mr_mode == 0) m_ready = 1'b1;
        else m_ready = ((mcyc % 4) == 0) || ((mcyc % 4) == 3);
    end

    typedef struct packed { logic [AW-1:0] addr; logic [7:0] data; } wr_t;
    typedef struct packed { logic [7:0] data; logic last; } rd_t;
    wr_t wq[$];
    rd_t oq[$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor / scoreboard, sampled on the falling edge.
    int            cyc = 0;
    int            wr_cnt = 0, rd_cnt = 0, done_cnt = 0;
    int            start_len = 0, last_start_len = 0;
    int            first_cyc = 0, last_cyc = 0;
    logic          start_prev = 1'b0, stall_prev = 1'b0;
    logic [7:0]    stall_data = '0;
    logic [KW-1:0] cur_key = '0;

    initial forever begin
        wr_t we;
        rd_t re;
        @(negedge ap_clk);
        cyc++;
        if (ap_rst) begin
            start_prev = 1'b0; start_len = 0; stall_prev = 1'b0;
        end else begin
            if (in_mem_ce0 && in_mem_we0) begin
                wr_cnt++;
                if (wq.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL wr_extra: got write addr 0x%0h, required none", in_mem_address0);
                end else begin
                    we = wq.pop_front();
                    chk("wr_addr", 64'(in_mem_address0), 64'(we.addr));
                    chk("wr_data", 64'(in_mem_d0), 64'(we.data));
                end
            end
            if (k_ap_start) begin
                if (!start_prev) begin
                    chk("writes_before_start", 64'(wr_cnt), 64'(NP));
                    chk("working_key", 64'(k_working_key), 64'(cur_key));
                end
                start_len++;
            end else if (start_prev) begin
                last_start_len = start_len;
                start_len = 0;
            end
            start_prev = k_ap_start;
            if (stall_prev) begin
                chk("stall_valid", 64'(m_valid), 64'd1);
                chk("stall_data", 64'(m_data), 64'(stall_data));
            end
            stall_prev = m_valid && !m_ready;
            stall_data = m_data;
            if (m_valid && m_ready) begin
                rd_cnt++;
                if (rd_cnt == 1) first_cyc = cyc;
                last_cyc = cyc;
                if (oq.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL rd_extra: got beat 0x%0h, required none", m_data);
                end else begin
                    re = oq.pop_front();
                    chk("m_data", 64'(m_data), 64'(re.data));
                    chk("m_last", 64'(m_last), 64'(re.last));
                end
            end
            if (job_done) done_cnt++;
        end
    end

    task automatic preload(input logic [7:0] ob);
        for (int k = 0; k < NP; k++) omem[k] = ob + 8'(k);
    endtask

    task automatic push_out(input logic [7:0] ob);
        for (int k = 0; k < NP; k++) oq.push_back('{data: ob + 8'(k), last: (k == NP - 1)});
    endtask

    task automatic issue_cmd(input logic [KW-1:0] k, input bit hold);
        @(posedge ap_clk); #1;
        cmd_key = k; cmd_start = 1'b1; cur_key = k;
        wr_cnt = 0; rd_cnt = 0;
        if (!hold) begin
            @(posedge ap_clk); #1;
            cmd_start = 1'b0;
        end
    endtask

    // mode 0: s_valid held high; mode 1: s_valid toggles every cycle.
    task automatic load_frame(input int mode, input logic [7:0] ib);
        int i = 0;
        int n = 0;
        bit ph = 1'b1;
        for (int k = 0; k < NP; k++) wq.push_back('{addr: AW'(k), data: ib + 8'(k)});
        while (i < NP && n < 200) begin
            @(posedge ap_clk); #1;
            s_valid = (mode == 0) ? 1'b1 : ph;
            ph = !ph;
            s_data = ib + 8'(i);
            @(negedge ap_clk);
            if (s_valid && s_ready) i++;
            n++;
        end
        @(posedge ap_clk); #1;
        s_valid = 1'b0;
        chk("load_beats", 64'(i), 64'(NP));
    endtask

    // Returns at the falling edge of the cycle after the job_done pulse.
    task automatic wait_done(input int budget);
        int d0 = done_cnt;
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            @(posedge ap_clk); #1;
            n++;
        end
        chk("job_done_seen", 64'(done_cnt - d0), 64'd1);
        @(negedge ap_clk);
        chk("job_done_width", 64'(done_cnt - d0), 64'd1);
        chk("idle_after_fin", 64'(busy), 64'd0);
    endtask

    typedef struct {
        logic [KW-1:0] key;
        int            in_mode;
        int            rdy_d;
        int            done_d;
        int            mr;
        logic [7:0]    in_base;
        logic [7:0]    out_base;
        int            exp_start;
        int            exp_drain;   // 0: drain timing not checked
    } job_t;

    task automatic run_job(input job_t j);
        rdy_delay = j.rdy_d; done_delay = j.done_d; mr_mode = j.mr;
        preload(j.out_base);
        push_out(j.out_base);
        issue_cmd(j.key, 1'b0);
        chk("busy_in_load", 64'(busy), 64'd1);
        load_frame(j.in_mode, j.in_base);
        wait_done(400);
        chk("start_cycles", 64'(last_start_len), 64'(j.exp_start));
        chk("writes", 64'(wr_cnt), 64'(NP));
        chk("reads", 64'(rd_cnt), 64'(NP));
        if (j.exp_drain != 0) chk("drain_cycles", 64'(last_cyc - first_cyc + 1), 64'(j.exp_drain));
        chk("queues_empty", 64'(wq.size() + oq.size()), 64'd0);
    endtask

    job_t jobs[4];

    initial begin
        int lim;
        int d0;
        jobs[0] = '{6'h2A, 0, 1, 20, 0, 8'h00, 8'hF0, 2, 16};  // basic job
        jobs[1] = '{6'h11, 1, 1, 20, 0, 8'h80, 8'hF0, 2, 16};  // input backpressure
        jobs[2] = '{6'h3F, 0, 1,  8, 1, 8'h40, 8'h80, 2,  0};  // output backpressure
        jobs[3] = '{6'h01, 0, 5, 10, 0, 8'h10, 8'hA0, 6, 16};  // slow ap_ready

        ap_rst = 1'b1;
        repeat (3) @(posedge ap_clk);
        @(negedge ap_clk);
        chk("reset_state", 64'(ovec), 64'd0);
        @(posedge ap_clk); #1;
        ap_rst = 1'b0;

        for (int t = 0; t < 4; t++) run_job(jobs[t]);

        // Reset in the middle of DRAIN, right after the 7th accepted beat.
        rdy_delay = 1; done_delay = 5; mr_mode = 0;
        preload(8'h60);
        push_out(8'h60);
        issue_cmd(6'h22, 1'b0);
        load_frame(0, 8'h20);
        lim = cyc + 300;
        wait (rd_cnt >= 7 || cyc >= lim);
        ap_rst = 1'b1;
        chk("beats_before_reset", 64'(rd_cnt), 64'd7);
        d0 = done_cnt;
        @(posedge ap_clk);
        @(negedge ap_clk);
        chk("reset_mid_drain", 64'(ovec), 64'd0);
        @(posedge ap_clk); #1;
        ap_rst = 1'b0;
        wq.delete();
        oq.delete();
        repeat (10) @(posedge ap_clk);
        @(negedge ap_clk);
        chk("no_done_after_reset", 64'(done_cnt - d0), 64'd0);
        chk("idle_after_reset", 64'(busy), 64'd0);
        run_job(jobs[0]);

        // cmd_start held high through a job: the key change during RUN is
        // ignored and the second job begins only once back in IDLE.
        rdy_delay = 1; done_delay = 10; mr_mode = 0;
        preload(8'hC0);
        push_out(8'hC0);
        issue_cmd(6'h15, 1'b1);
        load_frame(0, 8'h30);
        repeat (4) @(posedge ap_clk);
        #1;
        cmd_key = 6'h33;
        @(negedge ap_clk);
        chk("hold_busy_run", 64'(busy), 64'd1);
        chk("hold_key_run", 64'(k_working_key), 64'h15);
        cur_key = 6'h33;
        push_out(8'hC0);
        wait_done(400);
        chk("hold_job1_writes", 64'(wr_cnt), 64'(NP));
        chk("hold_job1_reads", 64'(rd_cnt), 64'(NP));
        wr_cnt = 0; rd_cnt = 0;
        @(negedge ap_clk);
        chk("hold_restart_busy", 64'(busy), 64'd1);
        chk("hold_restart_key", 64'(k_working_key), 64'h33);
        @(posedge ap_clk); #1;
        cmd_start = 1'b0;
        load_frame(0, 8'h50);
        wait_done(400);
        chk("hold_job2_writes", 64'(wr_cnt), 64'(NP));
        chk("hold_job2_reads", 64'(rd_cnt), 64'(NP));
        chk("hold_queues_empty", 64'(wq.size() + oq.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no completion, required completion");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1);
    end

endmodule
